// File: rtl/switch_pkg.sv
// Shared switch definitions: default sizing, the send-queue entry descriptor and a
// saturating counter helper used by the optional statistics.
package switch_pkg;

    localparam int SWITCH_CORE_SIZE_DEF = 8;
    localparam int SEND_DEPTH_DEF       = 4;

    // Descriptor of one queued send: destination core plus the storage slot holding its payload.
    typedef struct packed {
        logic [$clog2(SWITCH_CORE_SIZE_DEF)-1:0] core_idx;
        logic [$clog2(SEND_DEPTH_DEF)-1:0]       slot;
    } send_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/send_fifo_mem.sv
// Register storage for the send queue: one write port, one asynchronous read port.
// Payload lanes carry IEEE-754 single-precision bit patterns.
module send_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int IDX_W  = 3,
    parameter int PTR_W  = 2
) (
    input  logic                         clock,
    input  logic                         we,
    input  logic [PTR_W-1:0]             waddr,
    input  logic [IDX_W-1:0]             widx,
    input  logic [WIDTH-1:0][31:0]       wdata,
    input  logic [PTR_W-1:0]             raddr,
    output logic [IDX_W-1:0]             ridx,
    output logic [WIDTH-1:0][31:0]       rdata
);

    logic [DEPTH-1:0][IDX_W-1:0]         idx_q, idx_d;
    logic [DEPTH-1:0][WIDTH-1:0][31:0]   data_q, data_d;

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        if (we) begin
            idx_d[waddr]  = widx;
            data_d[waddr] = wdata;
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clock) begin
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    assign ridx  = idx_q[raddr];
    assign rdata = data_q[raddr];

endmodule

// File: rtl/switch_send_buffer.sv
// Per-core transmit FIFO replaying core sends onto the Switch send handshake.
// Optional statistics counters are enabled with `define SWITCH_SEND_BUFFER_STATS_EN.
module switch_send_buffer
    import switch_pkg::*;
#(
    parameter int WIDTH                 = 64,
    parameter int SWITCH_CORE_SIZE      = SWITCH_CORE_SIZE_DEF,
    parameter int DEPTH                 = SEND_DEPTH_DEF,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE),
    parameter int PTR_SIZE              = $clog2(DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push_valid,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0] push_core_idx,
    input  logic [WIDTH-1:0][31:0]           push_data,
    output logic                             push_ready,
    output logic                             switch_send_ready,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
    output logic [WIDTH-1:0][31:0]           switch_send_data,
    input  logic                             switch_send_ok,
`ifdef SWITCH_SEND_BUFFER_STATS_EN
    output logic [31:0]                      stat_sent,
    output logic [31:0]                      stat_full_cycles,
    output logic [31:0]                      stat_wait_cycles,
`endif
    output logic                             empty,
    output logic [PTR_SIZE:0]                count
);

    localparam logic [PTR_SIZE:0] FULL_CNT = DEPTH[PTR_SIZE:0];

    logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_SIZE:0]   count_q, count_d;
    logic                push_fire, pop_fire;

    // Readiness depends only on count, so push_ready never sees switch_send_ok combinationally.
    assign push_ready        = (count_q != FULL_CNT);
    assign switch_send_ready = (count_q != '0);
    assign empty             = (count_q == '0);
    assign count             = count_q;
    assign push_fire         = push_valid && push_ready;
    assign pop_fire          = switch_send_ready && switch_send_ok;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    send_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (SWITCH_CORE_ADDR_SIZE),
        .PTR_W (PTR_SIZE)
    ) u_mem (
        .clock (clock),
        .we    (push_fire),
        .waddr (wr_ptr_q),
        .widx  (push_core_idx),
        .wdata (push_data),
        .raddr (rd_ptr_q),
        .ridx  (switch_send_core_idx),
        .rdata (switch_send_data)
    );

`ifdef SWITCH_SEND_BUFFER_STATS_EN
    logic [31:0] stat_sent_q, stat_sent_d;
    logic [31:0] stat_full_q, stat_full_d;
    logic [31:0] stat_wait_q, stat_wait_d;

    always_comb begin
        stat_sent_d = sat_inc(stat_sent_q, pop_fire);
        stat_full_d = sat_inc(stat_full_q, push_valid && !push_ready);
        stat_wait_d = sat_inc(stat_wait_q, switch_send_ready && !switch_send_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_sent_q <= '0;
            stat_full_q <= '0;
            stat_wait_q <= '0;
        end else begin
            stat_sent_q <= stat_sent_d;
            stat_full_q <= stat_full_d;
            stat_wait_q <= stat_wait_d;
        end
    end

    assign stat_sent        = stat_sent_q;
    assign stat_full_cycles = stat_full_q;
    assign stat_wait_cycles = stat_wait_q;
`endif

endmodule

// File: tb/tb_switch_send_buffer.sv
// Directed bench for switch_send_buffer: reset, latency, backpressure, wrap and reset-flush.
module tb_switch_send_buffer;

    localparam int WIDTH = 64;
    localparam int ADDR  = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   push_valid;
    logic [ADDR-1:0]        push_core_idx;
    logic [WIDTH-1:0][31:0] push_data;
    logic                   push_ready;
    logic                   switch_send_ready;
    logic [ADDR-1:0]        switch_send_core_idx;
    logic [WIDTH-1:0][31:0] switch_send_data;
    logic                   switch_send_ok;
    logic                   empty;
    logic [2:0]             count;
`ifdef SWITCH_SEND_BUFFER_STATS_EN
    logic [31:0]            stat_sent, stat_full_cycles, stat_wait_cycles;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    switch_send_buffer #(.WIDTH(WIDTH), .SWITCH_CORE_SIZE(8), .DEPTH(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .push_valid           (push_valid),
        .push_core_idx        (push_core_idx),
        .push_data            (push_data),
        .push_ready           (push_ready),
        .switch_send_ready    (switch_send_ready),
        .switch_send_core_idx (switch_send_core_idx),
        .switch_send_data     (switch_send_data),
        .switch_send_ok       (switch_send_ok),
`ifdef SWITCH_SEND_BUFFER_STATS_EN
        .stat_sent            (stat_sent),
        .stat_full_cycles     (stat_full_cycles),
        .stat_wait_cycles     (stat_wait_cycles),
`endif
        .empty                (empty),
        .count                (count)
    );

    // Single-precision bit pattern of a small non-negative integer.
    function automatic logic [31:0] fbits(input int n);
        int          e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 24; b++) if (n[b]) e = b;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < WIDTH; i++) push_data[i] = fbits(base + i);
    endtask

    initial begin
        int accepted;
        reset = 1'b1; push_valid = 1'b0; push_core_idx = '0; push_data = '0; switch_send_ok = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_push_ready", 32'(push_ready), 1);
        chk("rst_send_ready", 32'(switch_send_ready), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);

        // Single entry: presented the cycle after the push, gone the cycle after that.
        push_valid = 1'b1; push_core_idx = 3'd5; fill(0); switch_send_ok = 1'b1;
        chk("single_no_fallthrough", 32'(switch_send_ready), 0);
        step();
        push_valid = 1'b0;
        chk("single_ready", 32'(switch_send_ready), 1);
        chk("single_idx", 32'(switch_send_core_idx), 5);
        chk("single_data63", switch_send_data[63], 32'h427C_0000);
        chk("single_data5", switch_send_data[5], 32'h40A0_0000);
        step();
        chk("single_empty", 32'(empty), 1);

        // Fill with the Switch stalled; fifth push must be refused.
        switch_send_ok = 1'b0; accepted = 0;
        for (int k = 0; k < 5; k++) begin
            push_valid = 1'b1; push_core_idx = 3'(k); fill(10 * (k + 1));
            if (push_ready) accepted++;
            step();
        end
        push_valid = 1'b0;
        chk("fill_accepted", 32'(accepted), 4);
        chk("fill_count", 32'(count), 4);
        chk("fill_push_ready", 32'(push_ready), 0);
        for (int c = 0; c < 10; c++) begin
            chk("hold_idx", 32'(switch_send_core_idx), 0);
            chk("hold_data", switch_send_data[1], fbits(11));
            step();
        end
        switch_send_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_ready", 32'(switch_send_ready), 1);
            chk("drain_idx", 32'(switch_send_core_idx), 32'(k));
            chk("drain_data", switch_send_data[7], fbits(10 * (k + 1) + 7));
            step();
            if (k == 0) chk("drain_push_ready_back", 32'(push_ready), 1);
        end
        chk("drain_empty", 32'(empty), 1);

        // Simultaneous push and pop at count=1.
        switch_send_ok = 1'b0; push_valid = 1'b1; push_core_idx = 3'd6; fill(1);
        step();
        chk("sim_pre_count", 32'(count), 1);
        switch_send_ok = 1'b1; push_core_idx = 3'd2; fill(2);
        step();
        push_valid = 1'b0;
        chk("sim_count", 32'(count), 1);
        chk("sim_idx", 32'(switch_send_core_idx), 2);
        chk("sim_data", switch_send_data[0], fbits(2));
        step();
        chk("sim_empty", 32'(empty), 1);

        // Ten push/pop pairs wrap the pointers twice and more.
        push_valid = 1'b1; push_core_idx = 3'd0; fill(100);
        step();
        for (int j = 1; j < 10; j++) begin
            push_core_idx = 3'(j % 8); fill(100 + j);
            chk("wrap_idx", 32'(switch_send_core_idx), 32'((j - 1) % 8));
            chk("wrap_data", switch_send_data[3], fbits(100 + j - 1 + 3));
            step();
        end
        push_valid = 1'b0;
        chk("wrap_last_idx", 32'(switch_send_core_idx), 1);
        chk("wrap_last_data", switch_send_data[3], fbits(112));
        step();
        chk("wrap_empty", 32'(empty), 1);

        // Reset with entries held; a push coincident with reset is lost.
        switch_send_ok = 1'b0; push_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_core_idx = 3'(k + 1); fill(k);
            step();
        end
        chk("mid_count", 32'(count), 3);
        reset = 1'b1; switch_send_ok = 1'b1;
        step();
        reset = 1'b0; push_valid = 1'b0; switch_send_ok = 1'b0;
        chk("mid_send_ready", 32'(switch_send_ready), 0);
        chk("mid_count_zero", 32'(count), 0);
        chk("mid_empty", 32'(empty), 1);
        chk("mid_push_ready", 32'(push_ready), 1);
`ifdef SWITCH_SEND_BUFFER_STATS_EN
        chk("mid_stat_sent", stat_sent, 0);
        chk("mid_stat_full", stat_full_cycles, 0);
`endif
        step();
        chk("mid_stays_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_send_buffer.md
# switch_send_buffer

Per-core transmit queue between a MatCore/VecCore and the Switch send port. The core pushes (destination core index, WIDTH-element vector) entries without waiting on the network. The buffer replays them in order onto the Switch `send_ready`/`send_ok` handshake, so a core stalls only when the queue is full. One instance sits on each of the SWITCH_CORE_SIZE send ports of a processor top.

## Interface
- `WIDTH`, 64: shortreal elements per vector; must match the Switch.
- `SWITCH_CORE_SIZE`, 8: cores on the Switch.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `SWITCH_CORE_ADDR_SIZE`, $clog2(SWITCH_CORE_SIZE): auto-gen.
- `PTR_SIZE`, $clog2(DEPTH): auto-gen.

Ports:
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `push_valid`  in  1: core offers an entry.
- `push_core_idx`  in  SWITCH_CORE_ADDR_SIZE: destination core.
- `push_data`  in  shortreal[WIDTH]: payload.
- `push_ready`  out  1: entry accepted this cycle when `push_valid && push_ready`.
- `switch_send_ready`  out  1: head entry presented to the Switch.
- `switch_send_core_idx`  out  SWITCH_CORE_ADDR_SIZE: head destination.
- `switch_send_data`  out  shortreal[WIDTH]: head payload.
- `switch_send_ok`  in  1: Switch accepted the presented entry.
- `empty`  out  1: no entries held; the core gates `done` on it.
- `count`  out  PTR_SIZE+1: entries held.

## Operation
- Circular storage of DEPTH entries, with head pointer `rd_ptr`, tail pointer `wr_ptr` (PTR_SIZE bits, wrap modulo DEPTH) and `count`.
- Push fires on `push_valid && push_ready`. It writes `{push_core_idx, push_data}` at `wr_ptr` and increments `wr_ptr`.
- Pop fires on `switch_send_ready && switch_send_ok`. It increments `rd_ptr`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both in the same cycle: unchanged; the written and read slots differ.
- `push_ready = (count != DEPTH)`. There is no push while full, even if a pop fires in the same cycle. This keeps `push_ready` free of a combinational path from `switch_send_ok`.
- `switch_send_ready = (count != 0)`. `switch_send_core_idx` and `switch_send_data` are the head slot contents.
- Head outputs stay stable while `switch_send_ready` is high and `switch_send_ok` is low.
- `switch_send_ok` while `switch_send_ready` is low is ignored.
- `empty = (count == 0)`.
- Ordering is strict FIFO. No reordering by destination.
- Self-send (destination equals own index) is passed through unchanged; the Switch resolves it.

## Timing
- Reset values: `count=0`, both pointers 0, `push_ready=1`, `switch_send_ready=0`, `empty=1`. Storage contents are don't-care; data outputs are unspecified while `switch_send_ready=0`.
- Reset in mid-operation discards all entries. On the cycle after reset is sampled high, outputs take their reset values. A pop or push coincident with reset is lost.
- Latency: an entry pushed in cycle N is presented (`switch_send_ready=1`) in cycle N+1. There is no fall-through.
- Throughput: one pop per cycle while `switch_send_ok` stays high. When the Switch also accepts every cycle, a full queue drains at one entry per cycle.
- After a pop in cycle N, the next entry is presented in cycle N+1, provided count>0.
- Full boundary: after DEPTH pushes with no pop, `push_ready=0` from the next cycle. It returns to 1 the cycle after the first pop.
- Empty boundary: a simultaneous push and pop at count=1 leaves count=1, and the new entry is presented next cycle.

## Configuration
- `SWITCH_SEND_BUFFER_STATS_EN` defined adds three output ports, each reset to 0:
  - `stat_sent` [31:0]: counts pops.
  - `stat_full_cycles` [31:0]: counts cycles with `push_valid && !push_ready`.
  - `stat_wait_cycles` [31:0]: counts cycles with `switch_send_ready && !switch_send_ok`.
- All three counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `switch_pkg`: the default `SWITCH_CORE_SIZE`, the default `DEPTH`, and a typedef `send_entry_t` packing `core_idx` with a payload index. The payload array itself stays a parameterized module port.
- One sub-module, `send_fifo_mem`: DEPTH×(idx+WIDTH shortreal) register storage with one write port and one asynchronous read port. Pointer and count control stays in `switch_send_buffer`.

## Test plan
- **Reset:** after reset, expect `push_ready=1`, `switch_send_ready=0`, `empty=1`, `count=0`.
- **Single entry:** push idx=5 with data[i]=i at cycle 2, `switch_send_ok=1`.
  - Expect `switch_send_ready=1`, idx=5, data[63]=63.0 at cycle 3.
  - Expect `empty=1` at cycle 4.
- **Fill and backpressure:** with `switch_send_ok=0`, push 5 entries (idx 0..4).
  - Expect 4 accepted and `push_ready=0`, with idx=0 held stable for 10 cycles.
  - Raise `switch_send_ok`: expect idx 0,1,2,3 in consecutive cycles. The entry with idx=4 was never accepted and must not appear.
- **Simultaneous push/pop at count=1:** count stays 1, and the new idx is presented the next cycle.
- **Wrap-around:** 10 push/pop pairs with DEPTH=4; all 10 entries emerge in order with correct payloads.
- **Mid-operation reset:** reset with 3 entries held. Expect `switch_send_ready=0` and `count=0` next cycle; with `SWITCH_SEND_BUFFER_STATS_EN` defined, expect `stat_sent=0`.
